shiftreg_2_fpga: RTL and testbench

Reader-side driver for a 74HC165 parallel-in/serial-out shift register; the input-direction counterpart of the team's 74HC595 output driver. On a request it pulses the parallel load, then generates SRCLK pulses and samples the serial output MSB-first. The assembled byte is presented to fabric logic with a one-cycle valid strobe. It sits between the board-level 74HC165 pins and any logic that polls external switches or inputs.

---
 rtl/shiftreg_pkg.sv | 7 +
 rtl/shiftreg_2_fpga_if.sv | 7 +
 rtl/shiftreg_timer.sv | 14 +
 rtl/shiftreg_2_fpga.sv | 81 ++++++++
 tb/tb_shiftreg_2_fpga.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: timing defaults and FSM encoding shared by the 74HC165 reader and 74HC595 writer
package shiftreg_pkg;
  localparam int SR_N = 2;
  localparam int SR_PULSE_DURATION = 3;
  localparam int SR_SETUP_TIME = 3;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CLK_HI, DONE} state_t;
endpackage

// File: rtl/shiftreg_2_fpga_if.sv
// shiftreg_2_fpga_if: fabric request/byte handshake plus the 74HC165 pin bundle
interface shiftreg_2_fpga_if;
  logic REQ, RDY, VALID, SH_LD, SRCLK, CLK_INH, SER_IN;
  logic [7:0] BYTE_OUT;
  modport master(output REQ, SER_IN, input RDY, VALID, BYTE_OUT, SH_LD, SRCLK, CLK_INH);
  modport slave(input REQ, SER_IN, output RDY, VALID, BYTE_OUT, SH_LD, SRCLK, CLK_INH);
endinterface

// File: rtl/shiftreg_timer.sv
// shiftreg_timer: N-bit down-counter; expire rises load_val+1 edges after a load and stays high
module shiftreg_timer #(parameter int N = 2) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic         expire
);
  logic [N-1:0] cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else cnt <= load ? load_val : cnt - N'(cnt != '0);
  assign expire = cnt == '0;
endmodule

// File: rtl/shiftreg_2_fpga.sv
// shiftreg_2_fpga: 74HC165 reader; parallel load, 7 SRCLK pulses, MSB-first byte with a VALID strobe
module shiftreg_2_fpga
  import shiftreg_pkg::*;
#(
  parameter int N = SR_N,
  parameter int PULSE_DURATION = SR_PULSE_DURATION,
  parameter int SETUP_TIME = SR_SETUP_TIME
) (
  input logic CLK,
  input logic RST_N,
  shiftreg_2_fpga_if.slave bus
);
  localparam logic [N-1:0] P_LD = N'(PULSE_DURATION - 1);
  localparam logic [N-1:0] S_LD = N'(SETUP_TIME - 1);
  state_t state;
  logic [2:0] bits;
  logic [7:0] data;
  logic expire, ld_p, ld_s;
  // the timer is reloaded on every state change that starts a new P or S wait
  always_comb begin
    ld_p = ((state == IDLE || state == DONE) && bus.REQ) || (state == SETTLE && expire && bits != 3'd7);
    ld_s = expire && (state == LOAD || state == CLK_HI);
  end
  shiftreg_timer #(.N(N)) u_timer (
    .CLK(CLK),
    .RST_N(RST_N),
    .load(ld_p || ld_s),
    .load_val(ld_p ? P_LD : S_LD),
    .expire(expire)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      bits <= '0;
      data <= '0;
      bus.RDY <= 1'b1;
      bus.VALID <= 1'b0;
      bus.BYTE_OUT <= '0;
      bus.SH_LD <= 1'b1;
      bus.SRCLK <= 1'b0;
      bus.CLK_INH <= 1'b1;
    end else begin
      bus.VALID <= 1'b0;
      case (state)
        IDLE, DONE:
          if (bus.REQ) begin
            state <= LOAD;
            bus.RDY <= 1'b0;
            bus.SH_LD <= 1'b0;
            bus.CLK_INH <= 1'b0;
            bits <= '0;
          end else state <= IDLE;
        LOAD:
          if (expire) begin
            bus.SH_LD <= 1'b1;
            state <= SETTLE;
          end
        SETTLE:
          if (expire) begin
            data <= {data[6:0], bus.SER_IN};
            if (bits == 3'd7) begin
              state <= DONE;
              bus.VALID <= 1'b1;
              bus.BYTE_OUT <= {data[6:0], bus.SER_IN};
              bus.RDY <= 1'b1;
              bus.CLK_INH <= 1'b1;
            end else begin
              bus.SRCLK <= 1'b1;
              bits <= bits + 3'd1;
              state <= CLK_HI;
            end
          end
        CLK_HI:
          if (expire) begin
            bus.SRCLK <= 1'b0;
            state <= SETTLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_shiftreg_2_fpga.sv
// tb_shiftreg_2_fpga: 74HC165 chip models driving a default and a P=1,S=1 reader
module tb_shiftreg_2_fpga;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #21 clk = ~clk;

  shiftreg_2_fpga_if a_if();
  shiftreg_2_fpga_if b_if();
  shiftreg_2_fpga dut (.CLK(clk), .RST_N(rst_n), .bus(a_if));
  shiftreg_2_fpga #(.N(2), .PULSE_DURATION(1), .SETUP_TIME(1)) dut_f (.CLK(clk), .RST_N(rst_n), .bus(b_if));

  // 74HC165 model: load while SH/LD low, shift on SRCLK rise unless inhibited, QH after a delay
  logic [7:0] a_par = 8'h00, a_sr = 8'h00, b_par = 8'h00, b_sr = 8'h00;
  logic a_q = 1'b0, b_q = 1'b0;
  always @(negedge a_if.SH_LD or posedge a_if.SRCLK)
    if (!a_if.SH_LD) a_sr <= a_par;
    else if (!a_if.CLK_INH) a_sr <= {a_sr[6:0], 1'b0};
  always @(negedge b_if.SH_LD or posedge b_if.SRCLK)
    if (!b_if.SH_LD) b_sr <= b_par;
    else if (!b_if.CLK_INH) b_sr <= {b_sr[6:0], 1'b0};
  always @(a_sr) begin #10; a_q = a_sr[7]; end
  always @(b_sr) begin #30; b_q = b_sr[7]; end
  assign a_if.SER_IN = a_q;
  assign b_if.SER_IN = b_q;

  task automatic read_a(input logic [7:0] pat, output int lat, output int pulses, output int ldw,
                        output int hiw, output logic [7:0] b);
    logic prev = 1'b0;
    a_par = pat;
    a_if.REQ = 1'b1;
    lat = -1; pulses = 0; ldw = 0; hiw = 0; b = 8'h00;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      @(negedge clk);
      a_if.REQ = 1'b0;
      if (!a_if.SH_LD) ldw++;
      if (a_if.SRCLK) hiw++;
      if (a_if.SRCLK && !prev) pulses++;
      prev = a_if.SRCLK;
      if (a_if.VALID) begin lat = i; b = a_if.BYTE_OUT; end
    end
  endtask

  task automatic test_reset();
    a_if.REQ = 1'b0; b_if.REQ = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_if.RDY, a_if.VALID, a_if.SH_LD, a_if.SRCLK, a_if.CLK_INH} !== 5'b10101) begin
      errors++; $display("FAIL reset_pins got %b exp 10101", {a_if.RDY, a_if.VALID, a_if.SH_LD, a_if.SRCLK, a_if.CLK_INH});
    end
    checks++;
    if (a_if.BYTE_OUT !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", a_if.BYTE_OUT); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, pulses, ldw, hiw;
    logic [7:0] b;
    read_a(8'hA5, lat, pulses, ldw, hiw, b);
    checks++; if (lat != 48) begin errors++; $display("FAIL basic_latency got %0d exp 48", lat); end
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL basic_byte got %h exp a5", b); end
    checks++; if (pulses != 7) begin errors++; $display("FAIL basic_srclk_pulses got %0d exp 7", pulses); end
    checks++; if (ldw != 3) begin errors++; $display("FAIL basic_shld_width got %0d exp 3", ldw); end
    checks++; if (hiw != 21) begin errors++; $display("FAIL basic_srclk_high got %0d exp 21", hiw); end
    @(negedge clk);
    checks++;
    if ({a_if.VALID, a_if.RDY, a_if.BYTE_OUT} !== {2'b01, 8'hA5}) begin
      errors++; $display("FAIL basic_after valid=%b rdy=%b byte=%h exp 0 1 a5", a_if.VALID, a_if.RDY, a_if.BYTE_OUT);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pats [8];
    int lat, pulses, ldw, hiw;
    logic [7:0] b;
    pats = '{8'h80, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 4; k < 8; k++) pats[k] = 8'($urandom);
    foreach (pats[k]) begin
      read_a(pats[k], lat, pulses, ldw, hiw, b);
      checks++;
      if (b !== pats[k] || lat != 48) begin
        errors++; $display("FAIL pattern_%0d got %h lat %0d exp %h lat 48", k, b, lat, pats[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int vcnt = 0;
    int t [2] = '{-1, -1};
    logic [7:0] bv [2] = '{8'h00, 8'h00};
    a_par = 8'h3C;
    a_if.REQ = 1'b1;
    for (int i = 0; i < 300 && vcnt < 2; i++) begin
      @(negedge clk);
      if (a_if.SRCLK) a_par = 8'hC3;
      if (vcnt == 1) a_if.REQ = 1'b0;
      if (a_if.VALID) begin t[vcnt] = i; bv[vcnt] = a_if.BYTE_OUT; vcnt++; end
    end
    a_if.REQ = 1'b0;
    checks++; if (vcnt != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", vcnt); end
    checks++; if (t[0] != 48) begin errors++; $display("FAIL b2b_first_latency got %0d exp 48", t[0]); end
    checks++; if (t[1] - t[0] != 49) begin errors++; $display("FAIL b2b_spacing got %0d exp 49", t[1] - t[0]); end
    checks++;
    if (bv[0] !== 8'h3C || bv[1] !== 8'hC3) begin
      errors++; $display("FAIL b2b_bytes got %h %h exp 3c c3", bv[0], bv[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_req();
    int vcnt = 0;
    logic [7:0] pat = 8'($urandom);
    logic [7:0] b = 8'h00;
    a_par = pat;
    a_if.REQ = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      a_if.REQ = (i < 40 && !a_if.RDY && i % 2 == 1);
      if (a_if.VALID) begin vcnt++; b = a_if.BYTE_OUT; end
    end
    a_if.REQ = 1'b0;
    checks++; if (vcnt != 1) begin errors++; $display("FAIL ignore_req_valids got %0d exp 1", vcnt); end
    checks++; if (b !== pat) begin errors++; $display("FAIL ignore_req_byte got %h exp %h", b, pat); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int vcnt = 0;
    int lat, pl, ldw, hiw;
    logic prev = 1'b0;
    logic hit = 1'b0;
    logic [7:0] pat, b;
    a_par = 8'h5A;
    a_if.REQ = 1'b1;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      a_if.REQ = 1'b0;
      if (a_if.SRCLK && !prev) pulses++;
      prev = a_if.SRCLK;
      if (pulses == 4 && a_if.SRCLK) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got %b exp 1", hit); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.RDY, a_if.VALID, a_if.SH_LD, a_if.SRCLK, a_if.CLK_INH, a_if.BYTE_OUT} !== {5'b10101, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_pins got %b byte %h exp 10101 byte 00",
               {a_if.RDY, a_if.VALID, a_if.SH_LD, a_if.SRCLK, a_if.CLK_INH}, a_if.BYTE_OUT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_if.VALID) vcnt++;
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", vcnt); end
    pat = 8'($urandom);
    read_a(pat, lat, pl, ldw, hiw, b);
    checks++;
    if (b !== pat || lat != 48) begin errors++; $display("FAIL rstmid_reread got %h lat %0d exp %h lat 48", b, lat, pat); end
    @(negedge clk);
  endtask

  task automatic test_fast();
    int lat = -1;
    int pulses = 0, ldw = 0, hiw = 0;
    logic prev = 1'b0;
    logic [7:0] pat = 8'($urandom);
    logic [7:0] b = 8'h00;
    b_par = pat;
    b_if.REQ = 1'b1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(negedge clk);
      b_if.REQ = 1'b0;
      if (!b_if.SH_LD) ldw++;
      if (b_if.SRCLK) hiw++;
      if (b_if.SRCLK && !prev) pulses++;
      prev = b_if.SRCLK;
      if (b_if.VALID) begin lat = i; b = b_if.BYTE_OUT; end
    end
    checks++; if (lat != 16) begin errors++; $display("FAIL fast_latency got %0d exp 16", lat); end
    checks++; if (b !== pat) begin errors++; $display("FAIL fast_byte got %h exp %h", b, pat); end
    checks++; if (pulses != 7) begin errors++; $display("FAIL fast_srclk_pulses got %0d exp 7", pulses); end
    checks++; if (ldw != 1 || hiw != 7) begin errors++; $display("FAIL fast_widths got ld %0d hi %0d exp 1 7", ldw, hiw); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_ignore_req();
    test_reset_mid();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
